// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Data-memory request/response bundle between the MEM stage
//               (master) and the memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder with a word RAM,
//               programmable wait states and misalign/range error flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input wire               clk,
    input wire               reset,
    dmem_responder_if.slave  bus
);

    localparam int          c_aw       = $clog2(DEPTH);
    localparam int          c_cw       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int          c_load_int = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [c_cw-1:0] c_cnt_load = c_load_int[c_cw-1:0];
    localparam logic [31:0] c_depth32  = DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              w_commit;
    logic              w_write;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic              w_err;
    logic [c_aw-1:0]   w_idx;
    logic [31:0]       w_rd_word;
    logic [3:0]        w_we;

    // With zero wait states the commit edge is the accept edge, so the
    // request fields come straight from the bus rather than the latches.
    always_comb begin
        w_write = (state_q == ST_IDLE) ? bus.req_write : write_q;
        w_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
        w_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
        w_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
    end

    assign w_err = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= c_depth32);
    assign w_idx = w_addr[c_aw+1:2];

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        assign w_we[b]            = w_commit && w_write && !w_err && w_be[b];
        assign w_rd_word[8*b +: 8] = lane_mem[w_idx];

        always_ff @(posedge clk) begin
            if (w_we[b]) begin
                lane_mem[w_idx] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        w_commit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (WAIT_STATES == 0) begin
                        state_d  = ST_RESP;
                        w_commit = 1'b1;
                    end else begin
                        cnt_d   = c_cnt_load;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_commit) begin
            rdata_d = (w_err || w_write) ? 32'h0 : w_rd_word;
            err_d   = w_err;
        end

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (WAIT_STATES=2 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic rst0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    dmem_responder_if m_if ();
    dmem_responder_if z_if ();

    dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    dmem_responder #(.DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (z_if)
    );

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    logic [31:0] mem_m [256];
    logic [31:0] mem_z [16];
    exp_t        mq[$];
    exp_t        zq[$];
    int          m_acc[$];
    int          m_acc_cnt = 0;
    bit          rr_manual = 1'b0;
    bit          rr_val    = 1'b1;
    bit          rr_rand   = 1'b0;
    bit          z_done    = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: whole-request semantics in plain arithmetic.
    function automatic exp_t model_access(input bit z, input bit wr, input logic [31:0] addr,
                                          input logic [31:0] wd, input logic [3:0] be);
        exp_t        e;
        int          depth;
        int          word;
        logic [31:0] w;
        depth   = z ? 16 : 256;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if ((addr % 4) != 0 || (addr / 4) >= depth) begin
            e.err = 1'b1;
            return e;
        end
        word = int'(addr / 4);
        w    = z ? mem_z[word] : mem_m[word];
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (z) mem_z[word] = w; else mem_m[word] = w;
        end else begin
            e.rdata = w;
        end
        return e;
    endfunction

    // rsp_ready driver for the main instance
    initial begin
        m_if.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            m_if.rsp_ready = rr_manual ? rr_val : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Main monitor: latency, ready exclusion and response data against the queue front
    initial begin
        bit   prev_valid = 1'b0;
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (m_if.req_valid && m_if.req_ready) begin
                    m_acc.push_back(cyc);
                    m_acc_cnt++;
                end
                if (m_if.rsp_valid) begin
                    check(!m_if.req_ready, "req_ready_during_resp", 32'(m_if.req_ready), 32'h0);
                    if (!prev_valid) begin
                        if (m_acc.size() == 0) begin
                            check(1'b0, "latency_no_accept", 32'h0, 32'h1);
                        end else begin
                            a = m_acc.pop_front();
                            check((cyc - a) == 3, "latency", 32'(cyc - a), 32'd3);
                        end
                    end
                    if (mq.size() == 0) begin
                        check(1'b0, "unexpected_rsp", m_if.rsp_rdata, 32'h0);
                    end else begin
                        e = mq[0];
                        check(m_if.rsp_rdata == e.rdata, "rsp_rdata", m_if.rsp_rdata, e.rdata);
                        check(m_if.rsp_err == e.err, "rsp_err", 32'(m_if.rsp_err), 32'(e.err));
                        if (m_if.rsp_ready) void'(mq.pop_front());
                    end
                end
                prev_valid = m_if.rsp_valid && !m_if.rsp_ready;
            end
        end
    end

    // Zero-wait-state monitor: 1-cycle latency, accept every 2 cycles when streaming
    initial begin
        bit   seen = 1'b0;
        int   last_acc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst0) begin
                if (z_if.req_valid && z_if.req_ready) begin
                    if (seen) check((cyc - last_acc) == 2, "z_accept_spacing", 32'(cyc - last_acc), 32'd2);
                    last_acc = cyc;
                    seen     = 1'b1;
                end
                if (z_if.rsp_valid) begin
                    check((cyc - last_acc) == 1, "z_latency", 32'(cyc - last_acc), 32'd1);
                    if (zq.size() == 0) begin
                        check(1'b0, "z_unexpected_rsp", z_if.rsp_rdata, 32'h0);
                    end else begin
                        e = zq.pop_front();
                        check(z_if.rsp_rdata == e.rdata, "z_rsp_rdata", z_if.rsp_rdata, e.rdata);
                        check(z_if.rsp_err == e.err, "z_rsp_err", 32'(z_if.rsp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input bit hold, input bit abort);
        int n = 0;
        if (!abort) mq.push_back(model_access(1'b0, wr, addr, wd, be));
        m_if.req_valid = 1'b1;
        m_if.req_write = wr;
        m_if.req_addr  = addr;
        m_if.req_wdata = wd;
        m_if.req_be    = be;
        do begin @(negedge clk); n++; end while (!m_if.req_ready && n < 100);
        if (!m_if.req_ready) check(1'b0, "accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        if (!hold) m_if.req_valid = 1'b0;
    endtask

    task automatic z_issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int n = 0;
        zq.push_back(model_access(1'b1, wr, addr, wd, be));
        z_if.req_valid = 1'b1;
        z_if.req_write = wr;
        z_if.req_addr  = addr;
        z_if.req_wdata = wd;
        z_if.req_be    = be;
        do begin @(negedge clk); n++; end while (!z_if.req_ready && n < 100);
        if (!z_if.req_ready) check(1'b0, "z_accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mq.size() != 0 || m_if.rsp_valid) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check(1'b0, "idle_timeout", 32'(mq.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(m_if.req_ready == 1'b1, {tag, "_req_ready"}, 32'(m_if.req_ready), 32'h1);
        check(m_if.rsp_valid == 1'b0, {tag, "_rsp_valid"}, 32'(m_if.rsp_valid), 32'h0);
        check(m_if.rsp_rdata == 32'h0, {tag, "_rsp_rdata"}, m_if.rsp_rdata, 32'h0);
        check(m_if.rsp_err == 1'b0, {tag, "_rsp_err"}, 32'(m_if.rsp_err), 32'h0);
    endtask

    // Zero-wait-state stream: stores then loads, valid held throughout
    initial begin
        int n = 0;
        rst0 = 1'b1;
        z_if.req_valid = 1'b0; z_if.req_write = 1'b0; z_if.req_addr = 32'h0;
        z_if.req_wdata = 32'h0; z_if.req_be = 4'h0; z_if.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst0 = 1'b0;
        for (int i = 0; i < 16; i++) z_issue(1'b1, 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 16; i++) z_issue(1'b0, 32'(i * 4), $urandom, 4'($urandom));
        z_issue(1'b0, 32'h40, 32'h0, 4'hF);
        z_issue(1'b0, 32'h6, 32'h0, 4'hF);
        z_issue(1'b1, 32'h3C, 32'hCAFE_F00D, 4'b1010);
        z_issue(1'b0, 32'h3C, 32'h0, 4'h0);
        z_if.req_valid = 1'b0;
        while (zq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (zq.size() != 0) check(1'b0, "z_drain_timeout", 32'(zq.size()), 32'h0);
        z_done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        int r;
        logic [31:0] addr;
        reset = 1'b1;
        m_if.req_valid = 1'b0; m_if.req_write = 1'b0; m_if.req_addr = 32'h0;
        m_if.req_wdata = 32'h0; m_if.req_be = 4'h0;
        #12;
        check_reset_outputs("reset");
        check(z_if.req_ready == 1'b1, "z_reset_req_ready", 32'(z_if.req_ready), 32'h1);
        check(z_if.rsp_valid == 1'b0, "z_reset_rsp_valid", 32'(z_if.rsp_valid), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        rr_rand = 1'b1;

        for (int i = 0; i < 256; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0);

        // basic store/load, byte lanes, errors
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h13, 32'h0, 4'hF, 1'b0, 1'b0);
        issue(1'b1, 32'h400, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
        issue(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       addr = 32'($urandom_range(0, 255) * 4);
            else if (r == 8) addr = 32'($urandom_range(0, 255) * 4) | 32'($urandom_range(1, 3));
            else             addr = $urandom | 32'h0000_0400;
            issue(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), 1'b0, 1'b0);
        end

        // backpressure with req_valid held
        wait_idle();
        rr_manual = 1'b1;
        rr_val    = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
        a0 = m_acc_cnt;
        n  = 0;
        while (!m_if.rsp_valid && n < 20) begin @(negedge clk); n++; end
        check(m_if.rsp_valid == 1'b1, "bp_rsp_arrives", 32'(m_if.rsp_valid), 32'h1);
        repeat (5) begin
            @(negedge clk);
            check(m_if.rsp_valid == 1'b1, "bp_rsp_valid_held", 32'(m_if.rsp_valid), 32'h1);
            check(m_if.req_ready == 1'b0, "bp_req_ready_low", 32'(m_if.req_ready), 32'h0);
        end
        @(posedge clk);
        #1 rr_val = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 m_if.req_valid = 1'b0;
        @(negedge clk);
        check(m_if.rsp_valid == 1'b0, "bp_rsp_valid_drop", 32'(m_if.rsp_valid), 32'h0);
        check(m_if.req_ready == 1'b1, "bp_req_ready_back", 32'(m_if.req_ready), 32'h1);
        check(m_acc_cnt == a0, "bp_no_double_accept", 32'(m_acc_cnt), 32'(a0));
        rr_manual = 1'b0;

        // reset while a store waits
        wait_idle();
        issue(1'b1, 32'h30, 32'h77, 4'hF, 1'b0, 1'b0);
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_idle();
        issue(1'b1, 32'h30, 32'h55, 4'hF, 1'b0, 1'b1);
        check(m_if.req_ready == 1'b0, "in_wait_req_ready", 32'(m_if.req_ready), 32'h0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        m_acc.delete();
        mq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_idle();

        n = 0;
        while (!z_done && n < 2000) begin @(negedge clk); n++; end
        check(z_done, "z_done", 32'(z_done), 32'h1);
        check(mq.size() == 0, "main_drain", 32'(mq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
